uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 100 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding four byte requesters into one UART transmitter.
// Watches the transmitter handshake and flags a start that never happens.
module uart_tx_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] data_in,
  input  logic        tx_busy,
  output logic [3:0]  grant,
  output logic [7:0]  tx_data,
  output logic        tx_load,
  output logic [1:0]  active_id,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t     state, state_nx;
  logic [1:0] last_served;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic [7:0] cnt;
  logic       timed_out;

  // Search starts just past the last served index and wraps.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_served + 2'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign timed_out = (state == WAIT_BUSY) && !tx_busy
                     && (cnt == TO);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (found && !tx_busy) state_nx = LOAD;
      LOAD:
        state_nx = WAIT_BUSY;
      WAIT_BUSY:
        if (tx_busy) state_nx = WAIT_DONE;
        else if (timed_out) state_nx = IDLE;
      WAIT_DONE:
        if (!tx_busy) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 2'd3;
      cnt         <= '0;
      tx_data     <= '0;
      active_id   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == LOAD) begin
        active_id <= winner;
        tx_data   <= data_in[{winner, 3'b000} +: 8];
      end
      if (state == LOAD) begin
        last_served <= active_id;
        cnt         <= 8'd1;
      end else if (state == WAIT_BUSY) begin
        cnt <= cnt + 8'd1;
      end else begin
        cnt <= '0;
      end
      if (timed_out) err_timeout <= 1'b1;
    end
  end

  assign tx_load = (state == LOAD);
  assign grant   = tx_load ? (4'b0001 << active_id) : 4'b0000;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single request, round-robin,
// wrap/skip, timeout, blocked start and mid-transfer reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic        tx_busy;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic [1:0]  active_id;
  logic        busy;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_in     (data_in),
    .tx_busy     (tx_busy),
    .grant       (grant),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .active_id   (active_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One full transaction starting from IDLE with req already set.
  task automatic serve(input string tag,
                       input logic [1:0] id,
                       input logic [7:0] byte_exp,
                       input int hold);
    logic [31:0] saved;
    tick();
    chk({tag, ".grant"}, grant, 32'(4'b0001 << id));
    chk({tag, ".load"}, tx_load, 1);
    chk({tag, ".data"}, tx_data, byte_exp);
    chk({tag, ".id"}, active_id, id);
    chk({tag, ".busy"}, busy, 1);
    saved   = data_in;
    data_in = 32'hFFFF_FFFF;
    tick();
    chk({tag, ".wb_grant"}, grant, 0);
    chk({tag, ".wb_load"}, tx_load, 0);
    chk({tag, ".held"}, tx_data, byte_exp);
    data_in = saved;
    tx_busy = 1'b1;
    repeat (hold) tick();
    chk({tag, ".wd_busy"}, busy, 1);
    chk({tag, ".wd_grant"}, grant, 0);
    tx_busy = 1'b0;
    tick();
    chk({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    data_in = '0;
    tx_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.grant", grant, 0);
    chk("rst.load", tx_load, 0);
    chk("rst.data", tx_data, 0);
    chk("rst.id", active_id, 0);
    chk("rst.busy", busy, 0);
    chk("rst.err", err_timeout, 0);

    // single request
    req     = 4'b0001;
    data_in = 32'h0000_004D;
    tick();
    chk("single.grant", grant, 4'b0001);
    chk("single.load", tx_load, 1);
    chk("single.data", tx_data, 8'h4D);
    chk("single.id", active_id, 0);
    req = 4'b0000;
    tick();
    chk("single.wb_load", tx_load, 0);
    tx_busy = 1'b1;
    repeat (10) begin
      tick();
      chk("single.busy", busy, 1);
    end
    tx_busy = 1'b0;
    tick();
    chk("single.idle", busy, 0);

    // round robin from reset priority
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    req     = 4'b1111;
    data_in = 32'hA3A2_A1A0;
    serve("rr0", 2'd0, 8'hA0, 2);
    serve("rr1", 2'd1, 8'hA1, 2);
    serve("rr2", 2'd2, 8'hA2, 2);
    serve("rr3", 2'd3, 8'hA3, 2);
    serve("rr4", 2'd0, 8'hA0, 2);

    // wrap and skip
    req = 4'b1000;
    serve("only3", 2'd3, 8'hA3, 1);
    req = 4'b0100;
    serve("wrap2", 2'd2, 8'hA2, 1);

    // timeout: transmitter never starts
    req     = 4'b0001;
    data_in = 32'h0000_0055;
    tick();
    chk("to.load", tx_load, 1);
    chk("to.data", tx_data, 8'h55);
    req = 4'b0000;
    repeat (16) tick();
    chk("to.err_early", err_timeout, 0);
    chk("to.busy16", busy, 1);
    tick();
    chk("to.err", err_timeout, 1);
    chk("to.idle", busy, 0);
    req     = 4'b0010;
    data_in = 32'h0000_6600;
    serve("after_to", 2'd1, 8'h66, 1);
    chk("to.sticky", err_timeout, 1);

    // blocked start while transmitter still busy
    tx_busy = 1'b1;
    req     = 4'b0010;
    data_in = 32'h0000_7700;
    repeat (3) begin
      tick();
      chk("blk.load", tx_load, 0);
      chk("blk.busy", busy, 0);
    end
    tx_busy = 1'b0;
    serve("blk", 2'd1, 8'h77, 1);

    // reset during WAIT_DONE
    req     = 4'b1111;
    data_in = 32'hA3A2_A1A0;
    tick();
    chk("mr.id", active_id, 2);
    tick();
    tx_busy = 1'b1;
    tick();
    chk("mr.wd", busy, 1);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    tx_busy = 1'b0;
    chk("mr.grant", grant, 0);
    chk("mr.load", tx_load, 0);
    chk("mr.data", tx_data, 0);
    chk("mr.id0", active_id, 0);
    chk("mr.busy", busy, 0);
    chk("mr.err", err_timeout, 0);
    serve("mr.first", 2'd0, 8'hA0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
